// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) single-port memory arbiter with one-cycle pipelined responses
module mem_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic [31:0]       req0_wd,
  input  logic [3:0]        req0_be,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  input  logic [31:0]       req1_wd,
  input  logic [3:0]        req1_be,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [31:0]       resp0_rdata,
  output logic              resp1_valid,
  output logic [31:0]       resp1_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rd
);
  logic last_grant, pend_valid, pend_id, gnt0, gnt1;
  always_comb begin
    gnt1 = rst_n && req1_valid && (!req0_valid || ROUND_ROBIN == 0 || !last_grant);
    gnt0 = rst_n && req0_valid && !gnt1;
  end
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign mem_a = gnt1 ? req1_addr : gnt0 ? req0_addr : '0;
  assign mem_we = gnt1 ? req1_we : gnt0 ? req0_we : 1'b0;
  assign mem_wd = gnt1 ? req1_wd : gnt0 ? req0_wd : '0;
  assign mem_be = gnt1 ? req1_be : gnt0 ? req0_be : '0;
  assign resp0_valid = pend_valid && !pend_id;
  assign resp1_valid = pend_valid && pend_id;
  assign resp0_rdata = resp0_valid ? mem_rd : '0;
  assign resp1_rdata = resp1_valid ? mem_rd : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_id <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      pend_valid <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        pend_id <= gnt1;
        last_grant <= gnt1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of round-robin and fixed-priority arbiters against a reference model
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, req0_valid, req1_valid, req0_we, req1_we;
  logic [31:0] req0_addr, req1_addr, req0_wd, req1_wd, mem_rd;
  logic [3:0] req0_be, req1_be;
  logic a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid, a_mem_we;
  logic b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid, b_mem_we;
  logic [31:0] a_resp0_rdata, a_resp1_rdata, a_mem_a, a_mem_wd;
  logic [31:0] b_resp0_rdata, b_resp1_rdata, b_mem_a, b_mem_wd;
  logic [3:0] a_mem_be, b_mem_be;
  int errors = 0, checks = 0;
  int last_g[2], pend[2], gl[2];
  bit pwe[2];
  mem_arbiter #(.ROUND_ROBIN(1), .ADDR_W(32)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we), .req0_wd(req0_wd), .req0_be(req0_be), .req0_ready(a_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we), .req1_wd(req1_wd), .req1_be(req1_be), .req1_ready(a_req1_ready),
    .resp0_valid(a_resp0_valid), .resp0_rdata(a_resp0_rdata), .resp1_valid(a_resp1_valid), .resp1_rdata(a_resp1_rdata),
    .mem_a(a_mem_a), .mem_we(a_mem_we), .mem_wd(a_mem_wd), .mem_be(a_mem_be), .mem_rd(mem_rd)
  );
  mem_arbiter #(.ROUND_ROBIN(0), .ADDR_W(32)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_we(req0_we), .req0_wd(req0_wd), .req0_be(req0_be), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we), .req1_wd(req1_wd), .req1_be(req1_be), .req1_ready(b_req1_ready),
    .resp0_valid(b_resp0_valid), .resp0_rdata(b_resp0_rdata), .resp1_valid(b_resp1_valid), .resp1_rdata(b_resp1_rdata),
    .mem_a(b_mem_a), .mem_we(b_mem_we), .mem_wd(b_mem_wd), .mem_be(b_mem_be), .mem_rd(mem_rd)
  );
  task automatic check(string tag, logic [68:0] got, logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int winner(int rr, int lst);
    if (!rst_n) return -1;
    if (req0_valid && req1_valid) return rr != 0 ? 1 - lst : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction
  task automatic verify(int k, output int g);
    string nm = k == 0 ? "rr" : "fp";
    logic [1:0] rdy, rv;
    logic [68:0] mem, mexp;
    logic [31:0] rd0, rd1;
    rdy = k == 0 ? {a_req1_ready, a_req0_ready} : {b_req1_ready, b_req0_ready};
    rv = k == 0 ? {a_resp1_valid, a_resp0_valid} : {b_resp1_valid, b_resp0_valid};
    mem = k == 0 ? {a_mem_a, a_mem_we, a_mem_wd, a_mem_be} : {b_mem_a, b_mem_we, b_mem_wd, b_mem_be};
    rd0 = k == 0 ? a_resp0_rdata : b_resp0_rdata;
    rd1 = k == 0 ? a_resp1_rdata : b_resp1_rdata;
    g = winner(k == 0 ? 1 : 0, last_g[k]);
    mexp = g == 0 ? {req0_addr, req0_we, req0_wd, req0_be} : g == 1 ? {req1_addr, req1_we, req1_wd, req1_be} : '0;
    check({nm, "_ready"}, rdy, g == 0 ? 2'b01 : g == 1 ? 2'b10 : 2'b00);
    check({nm, "_mem"}, mem, mexp);
    check({nm, "_resp_valid"}, rv, pend[k] == 0 ? 2'b01 : pend[k] == 1 ? 2'b10 : 2'b00);
    if (!(pend[k] == 0 && pwe[k])) check({nm, "_rdata0"}, rd0, pend[k] == 0 ? mem_rd : 32'h0);
    if (!(pend[k] == 1 && pwe[k])) check({nm, "_rdata1"}, rd1, pend[k] == 1 ? mem_rd : 32'h0);
  endtask
  task automatic step();
    int g[2];
    #1;
    verify(0, g[0]);
    verify(1, g[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pend[k] = -1;
        last_g[k] = 1;
      end else begin
        pend[k] = g[k];
        pwe[k] = g[k] == 0 ? req0_we : g[k] == 1 ? req1_we : 1'b0;
        if (g[k] >= 0) last_g[k] = g[k];
      end
      gl[k] = g[k];
    end
    @(negedge clk);
  endtask
  task automatic rnd_req(int n);
    if (n == 0) begin
      req0_valid = $urandom_range(0, 2) != 0;
      req0_addr = $urandom;
      req0_we = $urandom_range(0, 1) == 1;
      req0_wd = $urandom;
      req0_be = 4'($urandom);
    end else begin
      req1_valid = $urandom_range(0, 2) != 0;
      req1_addr = $urandom;
      req1_we = $urandom_range(0, 1) == 1;
      req1_wd = $urandom;
      req1_be = 4'($urandom);
    end
  endtask
  task automatic idle();
    {req0_valid, req1_valid, req0_we, req1_we} = '0;
    {req0_addr, req1_addr, req0_wd, req1_wd, req0_be, req1_be} = '0;
  endtask
  initial begin
    int exp_rr[4] = '{0, 1, 0, 1};
    pend = '{-1, -1};
    last_g = '{1, 1};
    pwe = '{0, 0};
    rst_n = 1'b0;
    mem_rd = 32'h0;
    idle();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();
    {req0_valid, req1_valid} = 2'b11;
    req0_addr = 32'h40;
    req1_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      mem_rd = 32'hA000 + i;
      #1;
      check("tie_rr_order", a_req1_ready, exp_rr[i]);
      check("tie_fp_req1", {b_req1_ready, b_req0_ready}, 2'b10);
      step();
    end
    req1_valid = 1'b0;
    #1;
    check("fp_req0_after_drop", b_req0_ready, 1'b1);
    step();
    idle();
    req0_valid = 1'b1;
    req0_addr = 32'h100;
    #1;
    check("single_read_ready", a_req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    mem_rd = 32'hDEADBEEF;
    #1;
    check("single_read_rdata", {a_resp0_valid, a_resp0_rdata}, {1'b1, 32'hDEADBEEF});
    step();
    req1_valid = 1'b1;
    req1_we = 1'b1;
    req1_be = 4'b0011;
    req1_wd = 32'h12345678;
    req1_addr = 32'h20;
    #1;
    check("write_mem", {a_mem_we, a_mem_be, a_mem_a}, {1'b1, 4'b0011, 32'h20});
    step();
    idle();
    #1;
    check("write_resp", {a_resp1_valid, a_mem_we}, 2'b10);
    step();
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_addr = 32'h200 + 4 * i;
      mem_rd = $urandom;
      step();
    end
    idle();
    step();
    req0_valid = 1'b1;
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("reset_drops_resp", {a_resp0_valid, a_resp1_valid}, 2'b00);
    step();
    {req0_valid, req1_valid} = 2'b11;
    #1;
    check("tie_after_reset", a_req0_ready, 1'b1);
    step();
    gl = '{0, 1};
    for (int i = 0; i < 400; i++) begin
      if (!(req0_valid && gl[0] != 0)) rnd_req(0);
      if (!(req1_valid && gl[0] != 1)) rnd_req(1);
      mem_rd = $urandom;
      rst_n = $urandom_range(0, 40) != 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
